// File: rtl/port_rr_arbiter_pkg.sv
// Shared types and helpers for the three-way round-robin port arbiter.
package port_rr_arbiter_pkg;

  localparam int         NUM_REQ  = 3;
  localparam logic [1:0] SEL_IDLE = 2'd3;

  typedef enum logic {IDLE, BUSY} state_t;

  // Index 3 (the idle code) maps to no grant at all.
  function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] i);
    onehot3 = '0;
    if (i != SEL_IDLE) onehot3[i] = 1'b1;
  endfunction

endpackage

// File: rtl/port_rr_arbiter_pick.sv
// Combinational rotating-priority picker: scans req starting at ptr, first set bit wins.
module rr_pick3
  import port_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               any,
  output logic [1:0]         idx
);

  logic [1:0] base;
  logic [2:0] cand;

  assign base = (ptr == SEL_IDLE) ? 2'd0 : ptr;

  // Scan from lowest priority to highest so the highest-priority hit overwrites.
  always_comb begin
    any  = 1'b0;
    idx  = SEL_IDLE;
    cand = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = {1'b0, base} + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (req[cand[1:0]]) begin
        any = 1'b1;
        idx = cand[1:0];
      end
    end
  end

endmodule

// File: rtl/port_rr_arbiter.sv
// Round-robin sequencer sharing one port among three burst masters; drives the
// external 3:1 mux select and routes port_ready back to the current owner only.
module port_rr_arbiter
  import port_rr_arbiter_pkg::*;
#(
  parameter int LEN_W = 4
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic [NUM_REQ-1:0]         m_valid,
  input  logic                       port_ready,
  output logic [1:0]                 mux_sel,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         m_ready,
  output logic                       busy,
  output logic                       last_beat
);

  logic [NUM_REQ-1:0][LEN_W-1:0] len_a;
  assign len_a = req_len;

  state_t             state, state_n;
  logic [1:0]         owner, owner_n;
  logic [1:0]         rr_ptr, ptr_n;
  logic [LEN_W-1:0]   beat_cnt, cnt_n;
  logic [1:0]         nxt_ptr, pick_ptr, pick_idx;
  logic               pick_any, fire;

  assign nxt_ptr  = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
  // One picker serves both idle arbitration and end-of-burst handover.
  assign pick_ptr = (state == IDLE) ? rr_ptr : nxt_ptr;

  rr_pick3 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign fire      = (state == BUSY) && m_valid[owner] && port_ready;
  assign last_beat = fire && (beat_cnt == '0);
  assign m_ready   = (state == BUSY) ? (onehot3(owner) & {NUM_REQ{port_ready}}) : '0;

  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = beat_cnt;
    ptr_n   = rr_ptr;
    case (state)
      IDLE: if (pick_any) begin
        state_n = BUSY;
        owner_n = pick_idx;
        cnt_n   = len_a[pick_idx];
      end
      BUSY: if (fire) begin
        if (beat_cnt != '0) begin
          cnt_n = beat_cnt - 1'b1;
        end else begin
          ptr_n = nxt_ptr;
          if (pick_any) begin
            owner_n = pick_idx;
            cnt_n   = len_a[pick_idx];
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      gnt      <= '0;
      mux_sel  <= SEL_IDLE;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= ptr_n;
      beat_cnt <= cnt_n;
      gnt      <= (state_n == BUSY) ? onehot3(owner_n) : '0;
      mux_sel  <= (state_n == BUSY) ? owner_n : SEL_IDLE;
      busy     <= (state_n == BUSY);
    end
  end

endmodule

// File: tb/tb_port_rr_arbiter.sv
// Scoreboarded bench for port_rr_arbiter: a cycle model pushes expected outputs,
// the negedge sample pops and compares; directed constant checks cover key sequences.
module tb_port_rr_arbiter;

  localparam int LEN_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        req = '0, m_valid = '0;
  logic [3*LEN_W-1:0] req_len = '0;
  logic              port_ready = 1'b0;
  logic [1:0]        mux_sel;
  logic [2:0]        gnt, m_ready;
  logic              busy, last_beat;

  port_rr_arbiter #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .m_valid(m_valid),
    .port_ready(port_ready), .mux_sel(mux_sel), .gnt(gnt), .m_ready(m_ready),
    .busy(busy), .last_beat(last_beat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [2:0] gnt;
    logic [2:0] mrdy;
    logic       busy;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0, checks = 0;

  bit mb;
  int mo, mc, mp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  function automatic logic [3*LEN_W-1:0] lens(input int a, input int b, input int c);
    return {LEN_W'(c), LEN_W'(b), LEN_W'(a)};
  endfunction

  task automatic model_reset();
    mb = 0; mo = 0; mc = 0; mp = 0;
  endtask

  task automatic model_exp(output exp_t e);
    e.sel  = 2'd3; e.gnt = 3'b000; e.mrdy = 3'b000; e.busy = 1'b0; e.last = 1'b0;
    if (rst_n && mb) begin
      e.sel  = 2'(mo);
      e.gnt  = 3'b001 << mo;
      e.mrdy = port_ready ? (3'b001 << mo) : 3'b000;
      e.busy = 1'b1;
      e.last = m_valid[mo] && port_ready && (mc == 0);
    end
  endtask

  task automatic model_clk();
    int w;
    if (!rst_n) begin
      model_reset();
    end else if (!mb) begin
      w = pick(req, mp);
      if (w >= 0) begin mb = 1; mo = w; mc = int'(req_len[w*LEN_W +: LEN_W]); end
    end else if (m_valid[mo] && port_ready) begin
      if (mc > 0) mc--;
      else begin
        mp = (mo + 1) % 3;
        w  = pick(req, mp);
        if (w >= 0) begin mo = w; mc = int'(req_len[w*LEN_W +: LEN_W]); end
        else mb = 0;
      end
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic [2:0] r, input logic [3*LEN_W-1:0] l,
                      input logic [2:0] mv, input logic pr);
    exp_t e, o;
    req = r; req_len = l; m_valid = mv; port_ready = pr;
    model_exp(e);
    exp_q.push_back(e);
    @(negedge clk);
    o = exp_q.pop_front();
    chk("mux_sel",   mux_sel,   o.sel);
    chk("gnt",       gnt,       o.gnt);
    chk("m_ready",   m_ready,   o.mrdy);
    chk("busy",      busy,      o.busy);
    chk("last_beat", last_beat, o.last);
    model_clk();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_tbl [8] = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
  logic       bp_pr  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    model_reset();
    @(posedge clk); #1;

    // Reset held with random inputs
    repeat (3) step(3'($urandom), 12'($urandom), 3'($urandom), 1'($urandom));
    rst_n = 1'b1;
    repeat (2) step(3'b000, '0, 3'b000, 1'b0);

    // Single beat from requester 0
    chk("sb_idle", gnt, 3'b000);
    step(3'b001, lens(0, 0, 0), 3'b001, 1'b1);
    chk("sb_gnt", gnt, 3'b001);
    chk("sb_sel", mux_sel, 2'd0);
    chk("sb_last", last_beat, 1'b1);
    step(3'b000, lens(0, 0, 0), 3'b001, 1'b1);
    chk("sb_done", gnt, 3'b000);
    chk("sb_done_sel", mux_sel, 2'd3);

    // Fairness: after requester 1 finishes, req=011 hands to requester 0
    step(3'b010, lens(0, 0, 0), 3'b010, 1'b1);
    chk("fair_g1", gnt, 3'b010);
    step(3'b011, lens(0, 0, 0), 3'b010, 1'b1);
    chk("fair_wrap", gnt, 3'b001);
    step(3'b000, lens(0, 0, 0), 3'b001, 1'b1);

    // Contention from a fresh pointer
    rst_n = 1'b0;
    step(3'b000, '0, 3'b000, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_seq", gnt, rr_tbl[i]);
      step(3'b111, lens(1, 1, 1), 3'b111, 1'b1);
    end
    step(3'b000, lens(1, 1, 1), 3'b111, 1'b1);
    chk("rr_drain", gnt, 3'b000);

    // Backpressure on owner 2 (pointer now 1); non-owner valids ignored
    step(3'b100, lens(0, 0, 2), 3'b100, 1'b0);
    chk("bp_gnt", gnt, 3'b100);
    step(3'b000, lens(0, 0, 2), 3'b011, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", gnt, 3'b100);
      step(3'b000, lens(5, 5, 5), 3'b100, bp_pr[i]);
    end
    chk("bp_done", gnt, 3'b000);

    // Owner 0 drops req after first of 4 beats
    step(3'b001, lens(3, 0, 0), 3'b001, 1'b0);
    step(3'b001, lens(3, 0, 0), 3'b001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("drop_hold", gnt, 3'b001);
      step(3'b000, lens(0, 0, 0), 3'b001, 1'b1);
    end
    chk("drop_done", gnt, 3'b000);

    // Async reset mid-burst of owner 1 (pointer 1 before reset)
    step(3'b010, lens(0, 5, 0), 3'b010, 1'b0);
    step(3'b010, lens(0, 5, 0), 3'b010, 1'b1);
    chk("mr_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", gnt, 3'b000);
    chk("ar_sel", mux_sel, 2'd3);
    chk("ar_busy", busy, 1'b0);
    chk("ar_mrdy", m_ready, 3'b000);
    chk("ar_last", last_beat, 1'b0);
    model_reset();
    @(posedge clk); #1;
    step(3'b111, lens(0, 0, 0), 3'b010, 1'b1);
    rst_n = 1'b1;
    step(3'b111, lens(0, 0, 0), 3'b000, 1'b0);
    chk("ar_ptr0", gnt, 3'b001);
    step(3'b000, lens(0, 0, 0), 3'b001, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/port_rr_arbiter.md
Name: port_rr_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 32-bit datapath port (e.g. a memory or bus port) between three requesters.
- Drives the 2-bit select of the team's existing 3:1 32-bit mux that feeds the port.
  - Select 0/1/2 picks requester 0/1/2.
  - Select 3 is the idle code; the mux outputs zero for it.
- Tracks per-grant bursts and gates the port's ready back to the owning requester only.
- Sits between the three masters and the shared port; owns no data path itself.

Parameters:
LEN_W, 4, width of burst-length field; value L means L+1 beats (1..2^LEN_W).

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  3  per-requester request, bit i = requester i
req_len  input  3*LEN_W  per-requester burst length, requester i in bits [i*LEN_W +: LEN_W]; sampled at grant
m_valid  input  3  per-requester beat valid
port_ready  input  1  shared port accepts a beat
mux_sel  output  2  select to the 3:1 mux; 0/1/2 = owner, 3 = idle
gnt  output  3  one-hot grant, registered
m_ready  output  3  port_ready routed to owner bit only; others 0
busy  output  1  high while a grant is held
last_beat  output  1  high in the cycle the final beat of a burst fires

Behaviour:
- Reset (async, rst_n low) sets:
  - state=IDLE, gnt=3'b000, mux_sel=2'd3, busy=0;
  - rr_ptr=0, beat_cnt=0, owner=0.
  - Combinational outputs follow: m_ready=0, last_beat=0.
- All state is registered on clk rising edge. m_ready and last_beat are combinational from state plus inputs.
- States: IDLE, BUSY.
- Arbitration (rr_pick):
  - Priority order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3) over the req vector.
  - The first set bit wins.
- IDLE behaviour:
  - Outputs: mux_sel=3, gnt=0, busy=0, m_ready=0.
  - If any req bit is set in cycle N, then at edge N+1:
    - state=BUSY, owner=winner, gnt=onehot(winner), mux_sel=winner, busy=1;
    - beat_cnt=req_len[winner].
  - Grant latency is 1 cycle from req.
- BUSY behaviour:
  - m_ready[owner]=port_ready; other m_ready bits are 0.
  - fire = m_valid[owner] & port_ready.
  - fire with beat_cnt>0: beat_cnt decrements; grant held.
  - fire with beat_cnt==0: last_beat=1 this cycle; rr_ptr <= (owner+1) mod 3. Same cycle, arbitrate with pointer (owner+1) mod 3 on the current req vector:
    - If there is a winner, the next cycle is BUSY with the new owner and beat_cnt=req_len[new]. Back-to-back handover, no idle bubble. The same owner may be re-granted if it is the only requester.
    - If there is no winner, the next cycle is IDLE (mux_sel=3, gnt=0).
  - No fire: all state held; port_ready low stalls indefinitely, with no timeout.
- Boundary rules:
  - req changes during BUSY, including the owner dropping req mid-burst, are ignored. The grant persists until the final beat fires.
  - m_valid from non-owners is ignored.
  - req_len changes after grant are ignored.
  - Reset asserted mid-burst immediately returns all outputs to reset values; the burst is abandoned.
  - rr_ptr only advances on burst completion, never in IDLE.
  - mux_sel and gnt always agree: gnt=0 iff mux_sel=3.

Decomposition:
- Shared package:
  - NUM_REQ=3
  - SEL_IDLE=2'd3
  - state enum {IDLE, BUSY}
  - a function mapping a 2-bit index to one-hot 3-bit
- One sub-module: rr_pick3. It is purely combinational: inputs req[2:0] and ptr[1:0]; outputs any, idx[1:0]. It is instantiated once and reused for both IDLE and handover arbitration.

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> mux_sel=3, gnt=000, busy=0, m_ready=000, last_beat=0. Release -> still idle with req=000.
- Single beat: req=001, req_len0=0, m_valid=001, port_ready=1 at cycle 0 -> gnt=001 and mux_sel=0 at cycle 1; last_beat=1 at cycle 1; idle at cycle 2 (req dropped).
- Contention: req=111 held, all req_len=1, m_valid=111, port_ready=1 -> gnt sequence 001,001,010,010,100,100,001, with no idle cycles between bursts.
- Fairness: after requester 1 completes, req=011 -> next grant is requester 0 (ptr=2 wraps to 0), not requester 1.
- Backpressure: owner 2, req_len=2, port_ready toggles 1,0,0,1,1 with m_valid=100 -> beat_cnt 2→1 on the first edge, held over the two stall cycles, last_beat on the fifth cycle. m_ready=100 only when port_ready=1.
- Mid-burst events: owner drops req after the first of 4 beats -> grant kept until the 4th beat fires. Separately, rst_n pulsed low mid-burst -> outputs return to reset values asynchronously, and rr_ptr=0 afterwards.
